// File: rtl/credit_stream_tx.sv
// credit_stream_tx
//   Transmitter end of a credit-based stream link. It accepts beats from a local
//   valid/ready stream and forwards them as a ready-less valid/data stream. A beat
//   is sent only when the remote receiver buffer has a free slot. Sending a beat
//   uses one credit, and each credit_i pulse returns one credit.
//
// Ports
//   clk_i      clock
//   rst_ni     asynchronous reset, active low
//   clr_i      synchronous clear, same effect as reset, highest priority
//   valid_i    upstream beat valid
//   ready_o    upstream ready (at least one credit available), register-derived
//   data_i     upstream payload
//   valid_o    link beat strobe, one cycle per beat
//   data_o     link payload, qualified by valid_o, holds last value otherwise
//   credit_i   one returned credit per high cycle
//   credits_o  current available credit count
//   idle_o     all credits home and no beat on the link
//   overflow_o sticky: credit returned while count already at MAX_CREDITS
module credit_stream_tx #(
  parameter int  WIDTH        = 1,
  parameter type T            = logic [WIDTH-1:0],
  parameter int  MAX_CREDITS  = 8,
  parameter int  INIT_CREDITS = MAX_CREDITS,
  localparam int CntWidth     = $clog2(MAX_CREDITS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  output T                    data_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credits_o,
  output logic                idle_o,
  output logic                overflow_o
);

  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MAX_CREDITS);
  localparam logic [CntWidth-1:0] CntInit = CntWidth'(INIT_CREDITS);

  if (MAX_CREDITS < 1) begin : g_bad_max
    $error("credit_stream_tx: MAX_CREDITS must be at least 1");
  end
  if (INIT_CREDITS < 0 || INIT_CREDITS > MAX_CREDITS) begin : g_bad_init
    $error("credit_stream_tx: INIT_CREDITS must be within 0..MAX_CREDITS");
  end

  logic [CntWidth-1:0] cnt;
  logic                beat_q;
  T                    data_q;
  logic                ovf_q;
  logic                accept;

  // ready depends only on the counter register, so there is no combinational
  // path from valid_i or credit_i to ready_o.
  assign ready_o = (cnt != '0);
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= CntInit;
      beat_q <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (clr_i) begin
      cnt    <= CntInit;
      beat_q <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      beat_q <= accept;
      if (accept) begin
        data_q <= data_i;
      end
      // When a beat is accepted and a credit returns in the same cycle, the
      // count does not change. This holds even at MAX, so no overflow is flagged.
      if (credit_i && !accept) begin
        if (cnt == CntMax) begin
          ovf_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (accept && !credit_i) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign valid_o    = beat_q;
  assign data_o     = data_q;
  assign credits_o  = cnt;
  assign overflow_o = ovf_q;
  assign idle_o     = (cnt == CntMax) && !beat_q;

`ifndef SYNTHESIS
  // Upstream rule: a stalled beat must stay valid with stable data until it is
  // accepted.
  a_upstream_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni || clr_i)
    (valid_i && !ready_o) |=> (valid_i && $stable(data_i))
  ) else $error("credit_stream_tx: upstream changed a stalled beat");
`endif

endmodule

// File: tb/tb_credit_stream_tx.sv
module tb_credit_stream_tx;

  localparam int W   = 8;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clr_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  data_i = '0;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic          credit_i = 1'b0;
  logic [CW-1:0] credits_o;
  logic          idle_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  credit_stream_tx #(
    .WIDTH(W),
    .MAX_CREDITS(MAX),
    .INIT_CREDITS(MAX)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .clr_i(clr_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i(data_i),
    .valid_o(valid_o),
    .data_o(data_o),
    .credit_i(credit_i),
    .credits_o(credits_o),
    .idle_o(idle_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Each record holds the inputs for one cycle and the outputs expected while
  // those inputs are applied. All outputs are register-derived, so the expected
  // values are the state left by the previous cycle.
  typedef struct {
    logic         clr;
    logic         vld;
    logic [W-1:0] dat;
    logic         crd;
    logic         e_rdy;
    logic         e_vo;
    logic [W-1:0] e_do;
    int           e_cnt;
    logic         e_idle;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, input logic vld, input logic [W-1:0] dat,
                     input logic crd, input logic rdy, input logic vo,
                     input logic [W-1:0] dout, input int cnt, input logic idle,
                     input logic ovf);
    vec_t v;
    v.clr = clr; v.vld = vld; v.dat = dat; v.crd = crd;
    v.e_rdy = rdy; v.e_vo = vo; v.e_do = dout; v.e_cnt = cnt;
    v.e_idle = idle; v.e_ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic vo,
                           input logic [W-1:0] dout, input int cnt,
                           input logic idle, input logic ovf);
    check({tag, ".ready"},    int'(ready_o),    int'(rdy));
    check({tag, ".valid"},    int'(valid_o),    int'(vo));
    check({tag, ".data"},     int'(data_o),     int'(dout));
    check({tag, ".credits"},  int'(credits_o),  cnt);
    check({tag, ".idle"},     int'(idle_o),     int'(idle));
    check({tag, ".overflow"}, int'(overflow_o), int'(ovf));
  endtask

  initial begin
    //   clr vld data   crd | rdy vo  dout   cnt idle ovf
    // burst of beats, credits run out, stall
    add(0, 1, 8'hA0, 0,   1, 0, 8'h00, 4, 1, 0);
    add(0, 1, 8'hA1, 0,   1, 1, 8'hA0, 3, 0, 0);
    add(0, 1, 8'hA2, 0,   1, 1, 8'hA1, 2, 0, 0);
    add(0, 1, 8'hA3, 0,   1, 1, 8'hA2, 1, 0, 0);
    add(0, 1, 8'hA4, 0,   0, 1, 8'hA3, 0, 0, 0);
    // credit while ready low: ready rises only next cycle
    add(0, 1, 8'hA4, 1,   0, 0, 8'hA3, 0, 0, 0);
    add(0, 1, 8'hA4, 0,   1, 0, 8'hA3, 1, 0, 0);
    add(0, 1, 8'hA5, 0,   0, 1, 8'hA4, 0, 0, 0);
    // credit and valid at count 0: no accept, count goes to 1
    add(0, 1, 8'hA5, 1,   0, 0, 8'hA4, 0, 0, 0);
    // accept and credit together: count unchanged
    add(0, 1, 8'hA5, 1,   1, 0, 8'hA4, 1, 0, 0);
    add(0, 0, 8'h00, 1,   1, 1, 8'hA5, 1, 0, 0);
    add(0, 1, 8'hB0, 1,   1, 0, 8'hA5, 2, 0, 0);
    add(0, 0, 8'h00, 1,   1, 1, 8'hB0, 2, 0, 0);
    add(0, 0, 8'h00, 1,   1, 0, 8'hB0, 3, 0, 0);
    add(0, 0, 8'h00, 0,   1, 0, 8'hB0, 4, 1, 0);
    // credit at MAX: overflow, sticky
    add(0, 0, 8'h00, 1,   1, 0, 8'hB0, 4, 1, 0);
    add(0, 0, 8'h00, 0,   1, 0, 8'hB0, 4, 1, 1);
    add(0, 1, 8'hC0, 0,   1, 0, 8'hB0, 4, 1, 1);
    add(0, 1, 8'hC1, 0,   1, 1, 8'hC0, 3, 0, 1);
    // clear ignores valid and credit in its cycle
    add(1, 1, 8'hC2, 1,   1, 1, 8'hC1, 2, 0, 1);
    // accept and credit at MAX: count stays, no overflow
    add(0, 1, 8'hD0, 1,   1, 0, 8'h00, 4, 1, 0);
    add(0, 0, 8'h00, 0,   1, 1, 8'hD0, 4, 0, 0);
    add(0, 0, 8'h00, 0,   1, 0, 8'hD0, 4, 1, 0);

    // reset state
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_all("reset", 1, 0, 8'h00, 4, 1, 0);

    foreach (vecs[i]) begin
      clr_i    = vecs[i].clr;
      valid_i  = vecs[i].vld;
      data_i   = vecs[i].dat;
      credit_i = vecs[i].crd;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vo,
                vecs[i].e_do, vecs[i].e_cnt, vecs[i].e_idle, vecs[i].e_ovf);
      @(negedge clk_i);
    end
    clr_i = 0; valid_i = 0; credit_i = 0; data_i = '0;
    @(negedge clk_i);

    // asynchronous reset in the middle of a burst
    valid_i = 1; data_i = 8'hE0;
    @(negedge clk_i);
    data_i = 8'hE1;
    @(negedge clk_i);
    data_i = 8'hE2;
    @(negedge clk_i);
    data_i = 8'hE3;
    #1;
    check_all("midburst", 1, 1, 8'hE2, 1, 0, 0);
    rst_ni = 1'b0;
    #1;
    check_all("async_rst", 1, 0, 8'h00, 4, 1, 0);
    @(posedge clk_i);
    #1;
    check_all("rst_held", 1, 0, 8'h00, 4, 1, 0);
    valid_i = 0; data_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_all("post_rst", 1, 0, 8'h00, 4, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
